// File: rtl/keypad_pkg.sv
// Shared types and helpers for the key scanner: event encoding and ms-to-tick conversion.
package keypad_pkg;

    typedef enum logic [1:0] {
        EV_NONE    = 2'b00,
        EV_PRESS   = 2'b01,
        EV_RELEASE = 2'b10,
        EV_LONG    = 2'b11
    } evt_type_e;

    typedef struct packed {
        evt_type_e  t;
        logic [2:0] idx;
    } evt_t;

    function automatic int ms_to_ticks(input int ms, input int f_sample);
        return ms * f_sample / 1000;
    endfunction

endpackage

// File: rtl/key_filter.sv
// Per-key front end: 2-FF synchroniser, tick-driven debounce filter and long-press hold counter.
module key_filter #(
    parameter int DB_TICKS   = 20,
    parameter int LONG_TICKS = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_ev,
    output logic rel_ev,
    output logic long_ev
);
    localparam int CW = $clog2(DB_TICKS + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, rel_q;
    logic          s;

    assign s = ~sync2_q;

    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        hold_d   = hold_q;
        press_ev = 1'b0;
        rel_ev   = 1'b0;
        long_ev  = 1'b0;
        if (tick) begin
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DB_TICKS - 1)) begin
                cnt_d    = '0;
                level_d  = ~level_q;
                press_ev = ~level_q;
                rel_ev   = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Hold only counts ticks after the press tick; saturation gives one long event per press.
        if (!level_d) begin
            hold_d = '0;
        end else if (tick && level_q && hold_q != HW'(LONG_TICKS)) begin
            hold_d  = hold_q + 1'b1;
            long_ev = (hold_q == HW'(LONG_TICKS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            press_q <= press_ev;
            rel_q   <= rel_ev;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/key_event_scanner.sv
// Key scanner top: sample prescaler, per-key filters, pending-event arbiter and show-ahead event FIFO.
module key_event_scanner
    import keypad_pkg::*;
#(
    parameter int F_CLK       = 50000000,
    parameter int F_SAMPLE    = 1000,
    parameter int N_KEYS      = 6,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              evt_valid,
    output logic [4:0]        evt_data,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              ovf
);
    localparam int TICK_DIV   = F_CLK / F_SAMPLE;
    localparam int DB_TICKS   = ms_to_ticks(DEBOUNCE_MS, F_SAMPLE);
    localparam int LONG_TICKS = ms_to_ticks(LONG_MS, F_SAMPLE);
    localparam int PW         = $clog2(TICK_DIV);
    localparam int AW         = $clog2(FIFO_DEPTH);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    logic [N_KEYS-1:0] press_ev, rel_ev, long_ev;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_filter #(
            .DB_TICKS  (DB_TICKS),
            .LONG_TICKS(LONG_TICKS)
        ) u_filt (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .key_n   (key[k]),
            .level   (key_level[k]),
            .press   (key_press[k]),
            .rel     (key_release[k]),
            .press_ev(press_ev[k]),
            .rel_ev  (rel_ev[k]),
            .long_ev (long_ev[k])
        );
    end

    logic [N_KEYS-1:0] pp_q, pp_d, pl_q, pl_d, pr_q, pr_d;
    logic [N_KEYS-1:0] gp, gl, gr;
    evt_t              push_evt;
    logic              push_req, push_ok, pop, full, empty, drop;
    logic              ovf_q, ovf_d;

    // Lowest key wins; within a key press beats long beats release.
    always_comb begin
        push_req = 1'b0;
        push_evt = '0;
        gp       = '0;
        gl       = '0;
        gr       = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (!push_req) begin
                if (pp_q[k]) begin
                    push_req = 1'b1; gp[k] = 1'b1; push_evt.t = EV_PRESS;   push_evt.idx = 3'(k);
                end else if (pl_q[k]) begin
                    push_req = 1'b1; gl[k] = 1'b1; push_evt.t = EV_LONG;    push_evt.idx = 3'(k);
                end else if (pr_q[k]) begin
                    push_req = 1'b1; gr[k] = 1'b1; push_evt.t = EV_RELEASE; push_evt.idx = 3'(k);
                end
            end
        end
    end

    assign pop     = !empty && evt_ready;
    assign push_ok = push_req && (!full || pop);

    // New events only arrive on a tick; anything still pending then is dropped.
    always_comb begin
        pp_d = pp_q & ~({N_KEYS{push_ok}} & gp);
        pl_d = pl_q & ~({N_KEYS{push_ok}} & gl);
        pr_d = pr_q & ~({N_KEYS{push_ok}} & gr);
        drop = 1'b0;
        if (tick) begin
            drop = |{pp_d, pl_d, pr_d};
            pp_d = press_ev;
            pl_d = long_ev;
            pr_d = rel_ev;
        end
    end

    assign ovf_d = (ovf_q & ~clr_ovf) | drop;

    evt_t          mem_q [FIFO_DEPTH];
    evt_t          mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = push_evt;
            wr_d                = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pp_q    <= '0;
            pl_q    <= '0;
            pr_q    <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            presc_q <= presc_d;
            pp_q    <= pp_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
        end
    end

    assign evt_valid = !empty;
    assign evt_data  = mem_q[rd_q[AW-1:0]];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_event_scanner.sv
// Directed bench for key_event_scanner: debounce, long press, queue order, overflow and reset.
module tb_key_event_scanner;
    localparam int NK = 6;
    localparam int TD = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] key_level, key_press, key_release;
    logic          evt_valid, evt_ready = 1'b0, clr_ovf = 1'b0, ovf;
    logic [4:0]    evt_data;

    logic [4:0]    got[$];
    int            n_err = 0, n_chk = 0, press_cnt = 0;

    always #5 clk = ~clk;

    key_event_scanner #(
        .F_CLK(8000), .F_SAMPLE(1000), .N_KEYS(NK),
        .DEBOUNCE_MS(3), .LONG_MS(10), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .clr_ovf(clr_ovf), .ovf(ovf)
    );

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) got.push_back(evt_data);
        press_cnt <= press_cnt + $countones(key_press);
    end

    task automatic chk(input string tag, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit is_rel, input int k, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(is_rel ? key_release[k] : key_press[k]) && lat < 200);
    endtask

    initial begin
        int lat, base;
        @(negedge clk);
        chk("rst_level", key_level, 0);
        chk("rst_press", key_press, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_data", evt_data, 0);
        chk("rst_ovf", ovf, 0);
        clks(1);
        rst_n = 1'b1;

        // press, long press once, release
        clks(2);
        key[0] = 1'b0;
        wait_pulse(1'b0, 0, lat);
        chk("t1_press_lat", int'(lat >= 2*TD && lat <= 4*TD), 1);
        chk("t1_level", key_level[0], 1);
        chk("t1_valid_early", evt_valid, 0);
        @(negedge clk);
        chk("t1_valid", evt_valid, 1);
        chk("t1_data", evt_data, 5'b01_000);
        clks(1);
        evt_ready = 1'b1;
        clks(120);
        chk("t1_n_long", got.size(), 2);
        chk("t1_ev0", got[0], 5'b01_000);
        chk("t1_ev1", got[1], 5'b11_000);
        clks(100);
        chk("t1_long_once", got.size(), 2);
        key[0] = 1'b1;
        clks(40);
        chk("t1_n_rel", got.size(), 3);
        chk("t1_rel", got[2], 5'b10_000);
        chk("t1_level_rel", key_level[0], 0);
        got.delete();

        // short glitches never flip
        base = press_cnt;
        for (int i = 0; i < 5; i++) begin
            key[2] = 1'b0;
            clks(2*TD);
            key[2] = 1'b1;
            clks(2*TD);
        end
        clks(40);
        chk("t2_presses", press_cnt - base, 0);
        chk("t2_level", key_level[2], 0);
        chk("t2_events", got.size(), 0);
        chk("t2_ovf", ovf, 0);

        // simultaneous presses queue in index order
        key[1] = 1'b0; key[4] = 1'b0;
        clks(40);
        chk("t3_n", got.size(), 2);
        chk("t3_ev0", got[0], 5'b01_001);
        chk("t3_ev1", got[1], 5'b01_100);
        key[1] = 1'b1; key[4] = 1'b1;
        clks(40);
        chk("t3_n_rel", got.size(), 4);
        chk("t3_rel0", got[2], 5'b10_001);
        chk("t3_rel1", got[3], 5'b10_100);
        chk("t3_drained", evt_valid, 0);
        got.delete();

        // overflow with a stalled consumer
        evt_ready = 1'b0;
        key = '0;
        lat = 0;
        while (!ovf && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("t4_ovf", ovf, 1);
        chk("t4_valid", evt_valid, 1);
        chk("t4_head", evt_data, 5'b01_000);
        @(negedge clk);
        chk("t4_head_stable", evt_data, 5'b01_000);
        clks(1);
        evt_ready = 1'b1;
        clks(8);
        chk("t4_n", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("t4_order", got[i], {2'b01, 3'(i)});
        clr_ovf = 1'b1;
        clks(1);
        clr_ovf = 1'b0;
        chk("t4_clr", ovf, 0);
        key = '1;
        clks(40);
        chk("t4_n_rel", got.size(), 10);
        for (int i = 0; i < 6; i++) chk("t4_rel_order", got[4+i], {2'b10, 3'(i)});
        chk("t4_ovf_after", ovf, 0);
        got.delete();

        // short hold: press and release, no long
        key[3] = 1'b0;
        wait_pulse(1'b0, 3, lat);
        clks(5*TD);
        key[3] = 1'b1;
        wait_pulse(1'b1, 3, lat);
        chk("t5_rel_lat", int'(lat >= 2*TD && lat <= 4*TD), 1);
        clks(20);
        chk("t5_n", got.size(), 2);
        chk("t5_ev0", got[0], 5'b01_011);
        chk("t5_ev1", got[1], 5'b10_011);
        got.delete();

        // reset mid-operation discards everything
        evt_ready = 1'b0;
        key[0] = 1'b0; key[1] = 1'b0;
        clks(40);
        chk("t6_queued", evt_valid, 1);
        key[5] = 1'b0;
        clks(TD + 2);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", evt_valid, 0);
        chk("t6_level", key_level, 0);
        chk("t6_data", evt_data, 0);
        key = '1;
        clks(3);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        clks(100);
        chk("t6_stale", got.size(), 0);
        chk("t6_level_after", key_level, 0);
        chk("t6_valid_after", evt_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
